// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : bp_pkg
// Brief    : Shared mode constants, entry view type and counter helper.
// Revision : 1.0
// ============================================================================
package bp_pkg;

    localparam int BP_STATIC  = 0;
    localparam int BP_BIMODAL = 1;
    localparam int BP_GSHARE  = 2;

    // Upper bounds of the parameter space; the entry view is sized to them.
    localparam int BP_MAX_XLEN  = 64;
    localparam int BP_MAX_TAG_W = 32;
    localparam int BP_MAX_CTR_W = 16;

    typedef struct packed {
        logic                    valid;
        logic [BP_MAX_TAG_W-1:0] tag;
        logic [BP_MAX_XLEN-1:0]  target;
        logic [BP_MAX_CTR_W-1:0] ctr;
    } bp_entry_t;

    function automatic logic [BP_MAX_CTR_W-1:0] sat_inc_dec(
        input logic [BP_MAX_CTR_W-1:0] ctr,
        input logic                    dir,
        input int unsigned             ctr_w
    );
        logic [BP_MAX_CTR_W-1:0] max_v;
        max_v = BP_MAX_CTR_W'((32'd1 << ctr_w) - 32'd1);
        if (dir) begin
            return (ctr >= max_v) ? max_v : ctr + BP_MAX_CTR_W'(1);
        end
        return (ctr == '0) ? '0 : ctr - BP_MAX_CTR_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predictor_sat_ctr_array.sv
`default_nettype none
// ============================================================================
// Module   : bp_sat_ctr_array
// Brief    : Saturating-counter array, one read port, one RMW write port.
// Revision : 1.0
// ============================================================================
module bp_sat_ctr_array
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic [$clog2(ENTRIES)-1:0] rd_idx_i,
    output logic [CTR_W-1:0]           rd_ctr_o,
    input  logic                       wr_en_i,
    input  logic [$clog2(ENTRIES)-1:0] wr_idx_i,
    input  logic                       wr_set_i,
    input  logic                       wr_dir_i
);

    localparam logic [CTR_W-1:0] c_ctr_init  = CTR_W'(CTR_INIT);
    localparam logic [CTR_W-1:0] c_ctr_alloc = CTR_W'(1) << (CTR_W - 1);

    logic [CTR_W-1:0] r_ctr [ENTRIES];
    logic [CTR_W-1:0] w_wr_next;

    assign rd_ctr_o = r_ctr[rd_idx_i];

    // wr_set_i loads the weakly-taken allocation value, otherwise step the counter.
    always_comb begin
        w_wr_next = c_ctr_alloc;
        if (!wr_set_i) begin
            w_wr_next = CTR_W'(sat_inc_dec(BP_MAX_CTR_W'(r_ctr[wr_idx_i]), wr_dir_i, CTR_W));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= c_ctr_init;
            end
        end else if (wr_en_i) begin
            r_ctr[wr_idx_i] <= w_wr_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : BHT/BTB predictor (static, bimodal, gshare) with perf counters.
// Revision : 1.0
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 64,
    parameter int TAG_W    = 8,
    parameter int CTR_W    = 2,
    parameter int CTR_INIT = 1,
    parameter int MODE     = 1,
    parameter int GHR_W    = 6,
    parameter int PERF_W   = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [XLEN-1:0]   pc_i,
    output logic              pred_taken_o,
    output logic [XLEN-1:0]   pred_target_o,
    output logic [GHR_W-1:0]  pred_ghr_o,
    input  logic              upd_valid_i,
    input  logic [XLEN-1:0]   upd_pc_i,
    input  logic [GHR_W-1:0]  upd_ghr_i,
    input  logic              upd_taken_i,
    input  logic [XLEN-1:0]   upd_target_i,
    input  logic              upd_mispred_i,
    output logic [PERF_W-1:0] branch_cnt_o,
    output logic [PERF_W-1:0] mispred_cnt_o
);

    localparam int c_idx_w = $clog2(ENTRIES);

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [GHR_W-1:0]   r_ghr;
    logic [PERF_W-1:0]  r_branch_cnt;
    logic [PERF_W-1:0]  r_mispred_cnt;

    logic [c_idx_w-1:0] w_lk_idx;
    logic [c_idx_w-1:0] w_upd_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [TAG_W-1:0]   w_upd_tag;
    logic [CTR_W-1:0]   w_lk_ctr;
    bp_entry_t          w_lk_entry;
    logic               w_lk_hit;
    logic               w_upd_hit;
    logic               w_upd_en;
    logic               w_tbl_wr;
    logic               w_ctr_wr;
    logic               w_unused;

    assign w_lk_tag  = pc_i[c_idx_w+TAG_W+1:c_idx_w+2];
    assign w_upd_tag = upd_pc_i[c_idx_w+TAG_W+1:c_idx_w+2];

    generate
        if (MODE == BP_GSHARE) begin : g_gshare_idx
            assign w_lk_idx  = pc_i[c_idx_w+1:2] ^ c_idx_w'(r_ghr);
            assign w_upd_idx = upd_pc_i[c_idx_w+1:2] ^ c_idx_w'(upd_ghr_i);
        end else begin : g_direct_idx
            assign w_lk_idx  = pc_i[c_idx_w+1:2];
            assign w_upd_idx = upd_pc_i[c_idx_w+1:2];
        end
    endgenerate

    always_comb begin
        w_lk_entry        = '0;
        w_lk_entry.valid  = r_valid[w_lk_idx];
        w_lk_entry.tag    = BP_MAX_TAG_W'(r_tag[w_lk_idx]);
        w_lk_entry.target = BP_MAX_XLEN'(r_target[w_lk_idx]);
        w_lk_entry.ctr    = BP_MAX_CTR_W'(w_lk_ctr);
    end

    assign w_lk_hit = w_lk_entry.valid && (w_lk_entry.tag == BP_MAX_TAG_W'(w_lk_tag));

    generate
        if (MODE == BP_STATIC) begin : g_static_out
            assign pred_taken_o  = 1'b0;
            assign pred_target_o = '0;
        end else begin : g_dynamic_out
            assign pred_taken_o  = w_lk_hit && w_lk_entry.ctr[CTR_W-1];
            assign pred_target_o = w_lk_hit ? w_lk_entry.target[XLEN-1:0] : '0;
        end
    endgenerate

    assign pred_ghr_o    = r_ghr;
    assign branch_cnt_o  = r_branch_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

    // A not-taken miss leaves the table alone; any taken outcome (re)writes tag/target.
    assign w_upd_en  = upd_valid_i && (MODE != BP_STATIC);
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);
    assign w_tbl_wr  = rst_n_i && w_upd_en && upd_taken_i;
    assign w_ctr_wr  = w_upd_en && (w_upd_hit || upd_taken_i);

    bp_sat_ctr_array #(
        .ENTRIES  (ENTRIES),
        .CTR_W    (CTR_W),
        .CTR_INIT (CTR_INIT)
    ) u_ctr_array (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .rd_idx_i (w_lk_idx),
        .rd_ctr_o (w_lk_ctr),
        .wr_en_i  (w_ctr_wr),
        .wr_idx_i (w_upd_idx),
        .wr_set_i (!w_upd_hit),
        .wr_dir_i (upd_taken_i)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_valid <= '0;
        end else if (w_tbl_wr) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_tbl_wr) begin
            r_tag[w_upd_idx]    <= w_upd_tag;
            r_target[w_upd_idx] <= upd_target_i;
        end
    end

    // History is trained only by resolved branches, never speculatively.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ghr <= '0;
        end else if (upd_valid_i && (MODE == BP_GSHARE)) begin
            r_ghr <= GHR_W'({r_ghr, upd_taken_i});
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (upd_valid_i) begin
            if (r_branch_cnt != '1) begin
                r_branch_cnt <= r_branch_cnt + PERF_W'(1);
            end
            if (upd_mispred_i && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + PERF_W'(1);
            end
        end
    end

    assign w_unused = ^{pc_i, upd_pc_i, upd_ghr_i, w_lk_entry, w_lk_hit};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Directed bench for bimodal, gshare and static predictor instances.
// Revision : 1.0
// ============================================================================
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispred;

    logic        bim_taken, gsh_taken, sta_taken;
    logic [31:0] bim_target, gsh_target, sta_target;
    logic [5:0]  bim_ghr, gsh_ghr, sta_ghr;
    logic [3:0]  bim_bcnt, bim_mcnt;
    logic [31:0] gsh_bcnt, gsh_mcnt, sta_bcnt, sta_mcnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.MODE(1), .PERF_W(4)) u_bim (
        .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc),
        .pred_taken_o(bim_taken), .pred_target_o(bim_target), .pred_ghr_o(bim_ghr),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .branch_cnt_o(bim_bcnt), .mispred_cnt_o(bim_mcnt)
    );

    branch_predictor #(.MODE(2)) u_gsh (
        .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc),
        .pred_taken_o(gsh_taken), .pred_target_o(gsh_target), .pred_ghr_o(gsh_ghr),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .branch_cnt_o(gsh_bcnt), .mispred_cnt_o(gsh_mcnt)
    );

    branch_predictor #(.MODE(0)) u_sta (
        .clk_i(clk), .rst_n_i(rst_n), .pc_i(pc),
        .pred_taken_o(sta_taken), .pred_target_o(sta_target), .pred_ghr_o(sta_ghr),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_ghr_i(upd_ghr),
        .upd_taken_i(upd_taken), .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
        .branch_cnt_o(sta_bcnt), .mispred_cnt_o(sta_mcnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        upd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic upd(input logic [31:0] a, input logic t, input logic [31:0] tgt,
                       input logic mp, input logic [5:0] g);
        upd_valid   = 1'b1;
        upd_pc      = a;
        upd_taken   = t;
        upd_target  = tgt;
        upd_mispred = mp;
        upd_ghr     = g;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic look(input logic [31:0] a);
        pc = a;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ghr_m;
        logic       t;

        rst_n = 1'b0; pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0;
        upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;
        do_reset();

        // Reset state
        look(32'h100);
        chk("rst_taken",  32'(bim_taken), 32'd0);
        chk("rst_target", bim_target,     32'd0);
        chk("rst_bcnt",   32'(bim_bcnt),  32'd0);
        chk("rst_mcnt",   32'(bim_mcnt),  32'd0);
        chk("rst_ghr",    32'(gsh_ghr),   32'd0);

        // First allocation: weakly taken
        upd(32'h100, 1'b1, 32'h140, 1'b1, 6'd0);
        look(32'h100);
        chk("alloc_taken",  32'(bim_taken), 32'd1);
        chk("alloc_target", bim_target,     32'h140);
        chk("alloc_bcnt",   32'(bim_bcnt),  32'd1);
        chk("alloc_mcnt",   32'(bim_mcnt),  32'd1);

        // Saturate at 3, then two not-taken steps
        for (int i = 0; i < 4; i++) upd(32'h100, 1'b1, 32'h140, 1'b0, 6'd0);
        upd(32'h100, 1'b0, 32'h140, 1'b1, 6'd0);
        look(32'h100);
        chk("sat_nt1_taken", 32'(bim_taken), 32'd1);
        upd(32'h100, 1'b0, 32'h140, 1'b1, 6'd0);
        look(32'h100);
        chk("sat_nt2_taken",  32'(bim_taken), 32'd0);
        chk("sat_nt2_target", bim_target,     32'h140);
        chk("sat_bcnt",       32'(bim_bcnt),  32'd7);
        chk("sat_mcnt",       32'(bim_mcnt),  32'd3);

        // Not-taken miss must not allocate
        upd(32'h300, 1'b0, 32'h340, 1'b0, 6'd0);
        look(32'h300);
        chk("ntmiss_taken",  32'(bim_taken), 32'd0);
        chk("ntmiss_target", bim_target,     32'd0);

        // Aliasing: 0x100 and 0x200 share index 0 with tags 1 and 2
        upd(32'h100, 1'b1, 32'h140, 1'b1, 6'd0);
        upd(32'h100, 1'b1, 32'h140, 1'b0, 6'd0);
        look(32'h100);
        chk("alias_train", 32'(bim_taken), 32'd1);
        look(32'h200);
        chk("alias_miss_taken",  32'(bim_taken), 32'd0);
        chk("alias_miss_target", bim_target,     32'd0);
        upd(32'h200, 1'b1, 32'h280, 1'b1, 6'd0);
        look(32'h200);
        chk("alias_new_taken",  32'(bim_taken), 32'd1);
        chk("alias_new_target", bim_target,     32'h280);
        look(32'h100);
        chk("alias_old_taken",  32'(bim_taken), 32'd0);
        chk("alias_old_target", bim_target,     32'd0);

        // Same-cycle lookup and update: pre-update value until the edge
        pc = 32'h200;
        upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b0;
        upd_target = 32'h280; upd_mispred = 1'b1; upd_ghr = 6'd0;
        #1;
        chk("bypass_pre", 32'(bim_taken), 32'd1);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        #1;
        chk("bypass_post",   32'(bim_taken), 32'd0);
        chk("bypass_target", bim_target,     32'h280);
        chk("bim_bcnt12",    32'(bim_bcnt),  32'd12);
        chk("bim_mcnt6",     32'(bim_mcnt),  32'd6);

        // Unknown fetch PC must leave the table intact
        pc = 'x;
        @(posedge clk);
        #1;
        look(32'h200);
        chk("xpc_target", bim_target, 32'h280);

        // Static mode: never predicts, still counts
        chk("sta_taken",  32'(sta_taken), 32'd0);
        chk("sta_target", sta_target,     32'd0);
        chk("sta_bcnt",   sta_bcnt,       32'd12);
        chk("sta_mcnt",   sta_mcnt,       32'd6);

        // Gshare: alternating T/N at 0x80; mispredicts only at steps 0,2,4,6
        do_reset();
        ghr_m = 6'd0;
        for (int k = 0; k < 20; k++) begin
            t = (k % 2 == 0);
            look(32'h80);
            chk("gsh_ghr",  32'(gsh_ghr),   32'(ghr_m));
            chk("gsh_pred", 32'(gsh_taken), 32'((k >= 8) && t));
            upd(32'h80, t, 32'hC0, (k < 8) && t, ghr_m);
            ghr_m = {ghr_m[4:0], t};
            if (k == 7) chk("gsh_mcnt_warm", gsh_mcnt, 32'd4);
        end
        chk("gsh_mcnt_end", gsh_mcnt, 32'd4);
        chk("gsh_bcnt_end", gsh_bcnt, 32'd20);
        chk("gsh_ghr_end",  32'(gsh_ghr), 32'h2A);
        chk("bim_ghr_flat", 32'(bim_ghr), 32'd0);

        // Perf saturation at PERF_W=4, then reset coincident with an update
        do_reset();
        for (int i = 0; i < 20; i++) upd(32'h400, 1'b1, 32'h440, 1'b1, 6'd0);
        chk("perf_bcnt_sat", 32'(bim_bcnt), 32'd15);
        chk("perf_mcnt_sat", 32'(bim_mcnt), 32'd15);
        look(32'h400);
        chk("perf_trained", 32'(bim_taken), 32'd1);
        rst_n = 1'b0;
        upd(32'h500, 1'b1, 32'h540, 1'b1, 6'd0);
        rst_n = 1'b1;
        chk("rstupd_bcnt", 32'(bim_bcnt), 32'd0);
        chk("rstupd_mcnt", 32'(bim_mcnt), 32'd0);
        chk("rstupd_gsh",  gsh_bcnt,      32'd0);
        look(32'h500);
        chk("rstupd_noalloc",   32'(bim_taken), 32'd0);
        chk("rstupd_notarget",  bim_target,     32'd0);
        look(32'h400);
        chk("rstupd_discarded", 32'(bim_taken), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 5-stage RV32 pipeline. Successor to the fixed predict-not-taken and flush-on-taken scheme, in which branches resolve in ID.
- Looked up combinationally in IF with the fetch PC. Returns a taken prediction and a target.
- Trained by one update per resolved branch from ID.
- Parametrised in table depth, tag width, counter width and prediction mode: static, bimodal or gshare.
- Keeps saturating performance counters.

Parameters:
- XLEN, 32, data/PC width
- ENTRIES, 64, BHT/BTB entries; power of 2, ≥2
- TAG_W, 8, BTB tag bits stored per entry
- CTR_W, 2, saturating-counter width; ≥1
- CTR_INIT, 1, counter value after reset (weakly not-taken)
- MODE, 1, 0 = static not-taken, 1 = bimodal, 2 = gshare
- GHR_W, 6, global history bits; ≤ log2(ENTRIES), used only when MODE=2
- PERF_W, 32, performance counter width

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- pc_i  in  XLEN  fetch PC (IF)
- pred_taken_o  out  1  predict taken
- pred_target_o  out  XLEN  predicted target; valid when pred_taken_o=1
- pred_ghr_o  out  GHR_W  GHR snapshot used for this lookup; carried down the pipeline to ID
- upd_valid_i  in  1  one resolved branch this cycle; pulse once per branch (pipeline gates it with !stall)
- upd_pc_i  in  XLEN  PC of the resolved branch
- upd_ghr_i  in  GHR_W  snapshot returned with that branch
- upd_taken_i  in  1  actual outcome
- upd_target_i  in  XLEN  actual target (PC + offset)
- upd_mispred_i  in  1  prediction was wrong (direction or target)
- branch_cnt_o  out  PERF_W  resolved branches
- mispred_cnt_o  out  PERF_W  mispredictions

Behaviour:
- Decided interface fact: one clock; reset is synchronous and active-low, ports clk_i and rst_n_i.
- Index and tag:
  - IDX_W = log2(ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - MODE=2: idx ^= zero-extended GHR (lookup uses the current GHR; update uses upd_ghr_i).
- Entry contents: valid, tag, target, counter[CTR_W].
- Lookup is purely combinational, zero latency:
  - hit = valid & tag match.
  - pred_taken_o = hit & counter MSB.
  - pred_target_o = hit ? target : 0.
  - MODE=0: pred_taken_o is always 0, pred_target_o is 0, and the table is never written.
- Update, on a clock edge with upd_valid_i=1 and MODE≠0:
  - On hit: counter +1 if taken / −1 if not, saturating at 2^CTR_W−1 and 0. If taken, also write the target.
  - On miss with taken=1: allocate the entry. valid=1, tag and target written, counter = 2^(CTR_W−1) (weakly taken).
  - On miss with taken=0: no table write.
- GHR (MODE=2): on update, GHR ← {GHR[GHR_W−2:0], upd_taken_i}. The update is non-speculative.
- Same-cycle lookup and update to the same entry: lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- Performance counters:
  - branch_cnt_o +1 per upd_valid_i.
  - mispred_cnt_o +1 when upd_valid_i & upd_mispred_i.
  - Both saturate at 2^PERF_W−1 and never wrap.
  - They count in every MODE.
- Reset (rst_n_i=0 at an edge):
  - All valid bits, counters (to CTR_INIT), GHR and perf counters are cleared in that single cycle.
  - Outputs settle to: pred_taken_o=0, pred_target_o=0, pred_ghr_o=0, both counts=0.
  - An update coincident with reset is dropped; reset wins.
  - Reset mid-run discards all training.
- X/undefined on pc_i must not corrupt state; only update writes state.

Decomposition:
- Package bp_pkg holds:
  - mode constants BP_STATIC, BP_BIMODAL, BP_GSHARE;
  - an entry struct typedef (valid, tag, target, ctr);
  - the function sat_inc_dec(ctr, dir).
- One sub-module: bp_sat_ctr_array, the parametrised counter array with one read port, one write port and synchronous reset.
- Tag/target storage stays in the top level.

Test Plan:
- Reset, then lookup pc=0x100 → pred_taken_o=0, pred_target_o=0, counts=0.
- MODE=1: update pc=0x100, taken, target 0x140 → next cycle lookup 0x100 gives taken=1, target=0x140. Counter=2.
- Saturation (CTR_W=2): four taken updates at 0x100 → counter 3. Then one not-taken → still predicts taken. A second not-taken → predicts not-taken.
- Aliasing (ENTRIES=64): 0x100 and 0x200 map to the same index with different tags. Train 0x100, then look up 0x200 → miss, pred_taken_o=0. A taken update at 0x200 replaces the entry, so 0x100 now misses.
- MODE=2: alternating T/N branch at 0x80 for 20 updates → after warm-up, mispred_cnt_o stops incrementing. GHR shifts are visible on pred_ghr_o.
- PERF_W=4: 20 updates, all with upd_mispred_i=1 → both counters hold at 15. Then assert rst_n_i=0 with upd_valid_i=1 on the same edge → counters 0 and no allocation.
